// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Optional feature macro: DMEM_ARB_ROUND_ROBIN_EN (see dmem_arbiter.sv).
package dmem_arb_pkg;

  // Arbiter ownership state: IDLE = core path or burst start, BURST = beats 1..N-1
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int DEF_ADDR_STEP = 4;
  localparam int DEF_MAX_WAIT  = 15;

endpackage

// File: rtl/dmem_arb_burst_ctr.sv
// Burst address / beat counter. Loaded at grant with the address of beat 1
// and the number of beats still to go; steps once per burst beat.
module dmem_arb_burst_ctr #(
  parameter int AW        = 32,
  parameter int LENW      = 8,
  parameter int ADDR_STEP = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [AW-1:0]   load_addr,
  input  logic [LENW-1:0] load_rem,
  output logic [AW-1:0]   addr,
  output logic            last
);

  logic [LENW-1:0] remaining;

  // Load on grant, advance one word per beat; address wraps naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= load_addr;
      remaining <= load_rem;
    end else if (step) begin
      addr      <= addr + AW'(ADDR_STEP);
      remaining <= remaining - LENW'(1);
    end
  end

  assign last = (remaining == LENW'(1));

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the core load/store path (C)
// and a DMA/debug burst requester (D).
// Handshake: c_req is held until c_gnt (access happens in the c_gnt cycle);
// d_req is held until the one-cycle d_gnt pulse, which is also beat 0.
// Optional feature macro: DMEM_ARB_ROUND_ROBIN_EN -- when defined, the core
// and the burst alternate cycles during a burst instead of the core stalling.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int LENW      = 8,
  parameter int ADDR_STEP = DEF_ADDR_STEP,
  parameter int MAX_WAIT  = DEF_MAX_WAIT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            c_req,
  input  logic            c_we,
  input  logic [AW-1:0]   c_addr,
  input  logic [DW-1:0]   c_wdata,
  output logic            c_gnt,
  output logic [DW-1:0]   c_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [LENW-1:0] d_len,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_beat,
  output logic [DW-1:0]   d_rdata,
  output logic            d_done,
  output logic            m_we,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  input  logic [DW-1:0]   m_rdata
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  arb_state_t    state;
  logic [WW-1:0] wait_cnt;
  logic          burst_we;
  logic          start;
  logic          multi;
  logic          core_turn;
  logic          burst_beat;
  logic          cur_we;
  logic [AW-1:0] ctr_addr;
  logic          ctr_last;

  // D may start only from IDLE, when the core is quiet or D has waited long enough
  assign start = rst && (state == IDLE) && d_req &&
                 (!c_req || (wait_cnt == WW'(MAX_WAIT)));
  assign multi = (d_len > LENW'(1));

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic rr_turn;
  assign core_turn = (state == BURST) && c_req && rr_turn;
`else
  assign core_turn = 1'b0;
`endif

  assign burst_beat = (state == BURST) && !core_turn;
  assign cur_we     = (state == IDLE) ? d_we : burst_we;

  dmem_arb_burst_ctr #(
    .AW        (AW),
    .LENW      (LENW),
    .ADDR_STEP (ADDR_STEP)
  ) u_ctr (
    .clk       (clk),
    .rst       (rst),
    .load      (start && multi),
    .step      (burst_beat),
    .load_addr (d_addr + AW'(ADDR_STEP)),
    .load_rem  (d_len - LENW'(1)),
    .addr      (ctr_addr),
    .last      (ctr_last)
  );

  // Memory port steering and grants; everything forced low while in reset
  always_comb begin
    c_gnt   = 1'b0;
    d_gnt   = 1'b0;
    d_beat  = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    c_rdata = '0;
    d_rdata = '0;
    if (rst) begin
      m_addr  = c_addr;
      m_wdata = c_wdata;
      if (state == IDLE) begin
        if (start) begin
          d_gnt   = 1'b1;
          m_addr  = d_addr;
          m_wdata = d_wdata;
          if (d_len != '0) begin
            d_beat = 1'b1;
            m_we   = d_we;
          end
        end else begin
          c_gnt = c_req;
          m_we  = c_req && c_we;
        end
      end else if (core_turn) begin
        c_gnt = 1'b1;
        m_we  = c_we;
      end else begin
        d_beat  = 1'b1;
        m_addr  = ctr_addr;
        m_wdata = d_wdata;
        m_we    = burst_we;
      end
      if (c_gnt && !c_we) c_rdata = m_rdata;
      if (d_beat && !cur_we) d_rdata = m_rdata;
    end
  end

  // Ownership FSM, completion pulse, starvation counter and latched direction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      d_done   <= 1'b0;
      wait_cnt <= '0;
      burst_we <= 1'b0;
    end else begin
      d_done <= (start && !multi) || (burst_beat && ctr_last);
      case (state)
        IDLE:    if (start && multi) state <= BURST;
        BURST:   if (burst_beat && ctr_last) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (d_gnt) wait_cnt <= '0;
      else if (d_req && (wait_cnt != WW'(MAX_WAIT))) wait_cnt <= wait_cnt + WW'(1);
      if (start) burst_we <= d_we;
    end
  end

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // Alternation token: set after beat 0, flips every burst cycle, cleared at burst end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_turn <= 1'b0;
    else if (start && multi) rr_turn <= 1'b1;
    else if (state == BURST) rr_turn <= (burst_beat && ctr_last) ? 1'b0 : !rr_turn;
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations plus a
// per-cycle reference model of the arbitration rules and the memory contents.
module tb_dmem_arbiter;

  localparam int MAX_WAIT = 15;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        c_req, c_we, c_gnt;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic        d_req, d_we, d_gnt, d_beat, d_done;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [7:0]  d_len;
  logic        m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int total = 0;
  int bad   = 0;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_len(d_len), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_beat(d_beat), .d_rdata(d_rdata), .d_done(d_done),
    .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  // external memory: 256 words, word index = addr[9:2]
  logic [31:0] mem [0:255];
  assign m_rdata = mem[m_addr[9:2]];
  always @(posedge clk) if (m_we) mem[m_addr[9:2]] <= m_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model state
  logic [31:0] ref_mem [0:255];
  bit          r_busy, r_dir, r_turn, r_done;
  int          r_left, r_wait;
  logic [31:0] r_next;

  // scoreboard: every cycle, outputs derived from the rules and model memory
  always @(negedge clk) begin : cmp
    logic        e_cg, e_dg, e_db, e_we, nxt_done, st;
    logic [31:0] e_addr, e_wd, e_cr, e_dr;
    e_cg = 0; e_dg = 0; e_db = 0; e_we = 0; nxt_done = 0; st = 0;
    e_addr = 0; e_wd = 0; e_cr = 0; e_dr = 0;
    if (!rst) begin
      r_busy = 0; r_dir = 0; r_turn = 0; r_done = 0; r_left = 0; r_wait = 0; r_next = 0;
      check("rst_c_gnt", c_gnt, 0);
      check("rst_d_gnt", d_gnt, 0);
      check("rst_d_beat", d_beat, 0);
      check("rst_d_done", d_done, 0);
      check("rst_m_we", m_we, 0);
      check("rst_m_addr", m_addr, 0);
    end else begin
      if (!r_busy) begin
        st = d_req && (!c_req || r_wait == MAX_WAIT);
        if (st) begin
          e_dg = 1; r_dir = d_we;
          if (d_len != 0) begin
            e_db = 1; e_addr = d_addr; e_we = d_we; e_wd = d_wdata;
            if (!d_we) e_dr = ref_mem[d_addr[9:2]];
          end
          if (d_len <= 1) nxt_done = 1;
          else begin
            r_busy = 1; r_left = int'(d_len) - 1; r_next = d_addr + 32'd4; r_turn = 1;
          end
        end else if (c_req) begin
          e_cg = 1; e_addr = c_addr; e_we = c_we; e_wd = c_wdata;
          if (!c_we) e_cr = ref_mem[c_addr[9:2]];
        end
      end else if (RR && c_req && r_turn) begin
        e_cg = 1; e_addr = c_addr; e_we = c_we; e_wd = c_wdata;
        if (!c_we) e_cr = ref_mem[c_addr[9:2]];
        r_turn = !r_turn;
      end else begin
        e_db = 1; e_addr = r_next; e_we = r_dir; e_wd = d_wdata;
        if (!r_dir) e_dr = ref_mem[r_next[9:2]];
        r_next = r_next + 32'd4;
        r_left = r_left - 1;
        r_turn = !r_turn;
        if (r_left == 0) begin r_busy = 0; nxt_done = 1; r_turn = 0; end
      end
      check("c_gnt", c_gnt, e_cg);
      check("d_gnt", d_gnt, e_dg);
      check("d_beat", d_beat, e_db);
      check("d_done", d_done, r_done);
      check("m_we", m_we, e_we);
      check("c_rdata", c_rdata, e_cr);
      check("d_rdata", d_rdata, e_dr);
      if (e_db || e_cg) check("m_addr", m_addr, e_addr);
      if (e_we) begin
        check("m_wdata", m_wdata, e_wd);
        ref_mem[e_addr[9:2]] = e_wd;
      end
      if (e_dg) r_wait = 0;
      else if (d_req && r_wait < MAX_WAIT) r_wait++;
      r_done = nxt_done;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic wait_gnt(output int waited, output bit got);
    waited = 0; got = 0;
    for (int i = 0; i < 40; i++) begin
      settle();
      if (d_gnt) begin got = 1; break; end
      waited++;
      step();
    end
  endtask

  int waited, beats, cgs, span;
  bit got, cg, dg;
  logic [7:0] idx;

  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = 0; ref_mem[i] = 0; end
    rst = 0; c_req = 1; c_we = 0; c_addr = 0; c_wdata = 0;
    d_req = 1; d_we = 0; d_addr = 0; d_len = 1; d_wdata = 0;
    // reset holds everything low even with both requesters active
    settle();
    check("reset_c_gnt", c_gnt, 0);
    check("reset_d_gnt", d_gnt, 0);
    step(); step();
    rst = 1; c_req = 0; d_req = 0;

    // core write then read back, zero latency
    c_req = 1; c_we = 1; c_addr = 0; c_wdata = 32'hDEADBEEF;
    settle(); check("core_wr_gnt", c_gnt, 1); check("core_wr_mwe", m_we, 1);
    step(); c_we = 0;
    settle(); check("core_rd_gnt", c_gnt, 1); check("core_rd_data", c_rdata, 32'hDEADBEEF);
    step(); c_req = 0;

    // 4-beat write burst at 0x40
    d_req = 1; d_we = 1; d_addr = 32'h40; d_len = 4;
    for (int i = 0; i < 4; i++) begin
      d_wdata = 32'h1000 + i;
      settle();
      check("bw_addr", m_addr, 32'h40 + 4 * i);
      check("bw_beat", d_beat, 1);
      check("bw_gnt", d_gnt, (i == 0) ? 1 : 0);
      step(); d_req = 0;
    end
    settle(); check("bw_done", d_done, 1); check("bw_beat_end", d_beat, 0);
    step();

    // read the same burst back
    d_req = 1; d_we = 0; d_addr = 32'h40; d_len = 4;
    for (int i = 0; i < 4; i++) begin
      settle(); check("br_data", d_rdata, 32'h1000 + i);
      step(); d_req = 0;
    end

    // starvation: steady core stream, D forced through after MAX_WAIT cycles
    c_req = 1; c_we = 0; c_addr = 32'h8;
    d_req = 1; d_we = 1; d_addr = 32'h80; d_len = 1; d_wdata = 32'h55;
    wait_gnt(waited, got);
    check("starve_got", got, 1);
    check("starve_wait", waited, 15);
    check("starve_cgnt", c_gnt, 0);
    step(); d_req = 0;
    settle(); check("starve_done", d_done, 1); check("starve_core_back", c_gnt, 1);
    step(); c_req = 0;

    // zero-length burst: grant, no beat, no write, done next cycle
    d_req = 1; d_we = 1; d_addr = 32'h90; d_len = 0; d_wdata = 32'h77;
    settle(); check("len0_gnt", d_gnt, 1); check("len0_beat", d_beat, 0); check("len0_mwe", m_we, 0);
    step(); d_req = 0;
    settle(); check("len0_done", d_done, 1); check("len0_mwe2", m_we, 0);
    step();

    // address wrap at top of address space
    d_req = 1; d_we = 1; d_addr = 32'hFFFFFFFC; d_len = 2; d_wdata = 32'hA;
    settle(); check("wrap_a0", m_addr, 32'hFFFFFFFC);
    step(); d_req = 0; d_wdata = 32'hB;
    settle(); check("wrap_a1", m_addr, 32'h0); check("wrap_beat", d_beat, 1);
    step();
    settle(); check("wrap_done", d_done, 1);
    step();
    c_req = 1; c_we = 0; c_addr = 32'h0;
    settle(); check("wrap_mem0", c_rdata, 32'hB);
    step(); c_addr = 32'hFFFFFFFC;
    settle(); check("wrap_memtop", c_rdata, 32'hA);
    step();

    // core held during a 4-beat burst
    c_addr = 32'h44; d_req = 1; d_we = 0; d_addr = 32'h40; d_len = 4;
    wait_gnt(waited, got);
    check("stall_got", got, 1);
    beats = d_beat; cgs = c_gnt; span = 1;
    for (int i = 0; i < 20; i++) begin
      step(); d_req = 0;
      settle();
      if (d_done) break;
      beats += d_beat; cgs += c_gnt; span++;
    end
    check("stall_beats", beats, 4);
    check("stall_span", span, RR ? 7 : 4);
    check("stall_core_cycles", cgs, RR ? 3 : 0);
    step(); c_req = 0;

    // reset in the middle of a burst
    d_req = 1; d_we = 1; d_addr = 32'h100; d_len = 8; d_wdata = 32'h99;
    settle(); step(); d_req = 0;
    settle(); step();
    #1 rst = 0;
    settle(); check("mid_rst_beat", d_beat, 0); check("mid_rst_mwe", m_we, 0);
    step();
    settle(); check("mid_rst_done", d_done, 0);
    step(); rst = 1; c_req = 1; c_we = 0; c_addr = 32'h100;
    settle(); check("post_rst_cgnt", c_gnt, 1); check("post_rst_beat", d_beat, 0);
    check("post_rst_data", c_rdata, 32'h99);
    step(); c_req = 0;

    // back-to-back 2-beat bursts with d_req held
    d_req = 1; d_we = 0; d_addr = 32'h40; d_len = 2;
    for (int i = 0; i < 5; i++) begin
      settle(); check("b2b_gnt", d_gnt, (i % 2 == 0) ? 1 : 0);
      step();
    end
    d_req = 0;
    for (int i = 0; i < 3; i++) begin settle(); step(); end

    // mixed traffic, requests held until granted
    for (int n = 0; n < 400; n++) begin
      settle();
      cg = c_gnt; dg = d_gnt;
      step();
      if (cg || !c_req) begin
        idx = 8'($urandom_range(0, 255));
        c_req = ($urandom_range(0, 3) != 0); c_we = 1'($urandom_range(0, 1));
        c_addr = {22'd0, idx, 2'b00}; c_wdata = $urandom;
      end
      if (dg || !d_req) begin
        idx = 8'($urandom_range(0, 255));
        d_req = ($urandom_range(0, 7) == 0); d_we = 1'($urandom_range(0, 1));
        d_addr = {22'd0, idx, 2'b00}; d_len = 8'($urandom_range(0, 5));
      end
      d_wdata = $urandom;
    end
    c_req = 0; d_req = 0;
    for (int i = 0; i < 12; i++) begin settle(); step(); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
